wb_bus_arbiter: RTL and testbench
=================================

Name: wb_bus_arbiter

Overview:
- Two-master Wishbone B4 arbiter that shares one downstream bus between the CPU data port and the DMA engine's master port.
- Sits directly downstream of the DMA master interface. Its single master port drives the system interconnect (RAM, UART, timers).
- Grants whole bus tenures, from a master's CYC rising to its CYC falling. Grant uses round-robin or fixed-priority selection.

Parameters:
- FIXED_PRIORITY, 0: 0 = round-robin on ties; 1 = CPU always wins ties.
- TIMEOUT_CYCLES, 256: cycles without ACK/ERR before the watchdog aborts a tenure (only with ARB_TIMEOUT_EN).
- TO_WIDTH, 9: watchdog counter width; must hold TIMEOUT_CYCLES.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-low reset.
- cpu_wb  WB4.slave  —  CPU-side request port (CYC, STB, WE, SEL, ADR, DAT_O in; DAT_I, ACK, ERR out).
- dma_wb  WB4.slave  —  DMA-side request port, same signal set.
- bus_wb  WB4.master  —  shared downstream bus.
- grant  output  2  one-hot current owner: bit0 = CPU, bit1 = DMA; 00 = idle.
- timeout_irq  output  1  one-cycle pulse on watchdog abort (tied 0 without ARB_TIMEOUT_EN).

Behaviour:
- Reset (rst=0 at a clk edge):
  - State IDLE, grant=00, last_owner=DMA (so the CPU wins the first tie).
  - bus CYC/STB/WE=0; ADR, DAT_O, SEL=0.
  - Both slave ports: ACK=0, ERR=0, DAT_I=0.
  - Watchdog counter=0, timeout_irq=0.
  - A reset asserted mid-tenure drops the grant at that edge. No ACK is delivered after reset.
- FSM states: IDLE, OWN_CPU, OWN_DMA.
- IDLE:
  - Only cpu CYC=1 -> OWN_CPU. Only dma CYC=1 -> OWN_DMA.
  - Both asserted -> CPU if FIXED_PRIORITY=1; otherwise the master that is not last_owner.
  - Grant is registered: one cycle of latency from CYC to bus CYC.
- OWN_x:
  - bus CYC, STB, WE, SEL, ADR, DAT_O are combinationally muxed from master x.
  - bus DAT_I, ACK, ERR are routed to x only. The other port sees ACK=ERR=0 and DAT_I=0.
  - last_owner <= x on entry.
- Tenure end: when x's CYC=0 at an edge:
  - Next state is the other master's OWN state if that master's CYC=1 (direct handover, no idle cycle). Otherwise IDLE.
  - During that edge's cycle the bus CYC is 0, because the mux follows x's deasserted CYC.
- No preemption: a master keeps the bus for any number of back-to-back transfers while holding CYC.
- STB without CYC from any master is ignored.
- An ACK or ERR arriving on the bus while in IDLE is dropped.
- The arbiter never generates ACK itself. ERR is generated only by the watchdog.
- Combinational path master CYC -> bus CYC exists only within a granted tenure. There is no combinational path from request to grant.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - The watchdog counter increments each cycle the owner has STB=1 and bus ACK=ERR=0. It clears on ACK, ERR, or a state change.
  - When the counter reaches TIMEOUT_CYCLES-1:
    - The arbiter drives ERR=1 to the owner for exactly one cycle and pulses timeout_irq.
    - bus CYC is forced to 0 from the next cycle until the owner drops CYC.
    - The owner's tenure then ends per the normal rules.
- Undefined: no counter logic; a hung slave holds the grant indefinitely; timeout_irq tied 0.

Test Plan:
1. Reset, then cpu CYC/STB=1, ADR=0x1000, WE=0 -> grant=01 the next cycle; bus ADR=0x1000; slave ACK with DAT=0xDEADBEEF reaches cpu DAT_I; dma ACK stays 0.
2. From reset, cpu and dma raise CYC in the same cycle with FIXED_PRIORITY=0 -> CPU granted first. After CPU drops CYC, DMA is granted with no idle cycle. The next simultaneous request goes to CPU again (alternation).
3. FIXED_PRIORITY=1, both requesting repeatedly -> CPU wins every tie. DMA is granted only when cpu CYC=0.
4. DMA holds CYC for an 8-word burst (ADR 0x2000–0x201C) while the CPU requests from cycle 2 -> CPU is not granted until dma CYC falls; all 8 ACKs go to DMA, none to CPU.
5. rst=0 asserted mid-DMA tenure -> grant=00 and bus CYC=0 on the next edge. After release, a pending CPU request is granted first.
6. ARB_TIMEOUT_EN with TIMEOUT_CYCLES=16, slave never ACKs -> cpu ERR=1 and timeout_irq=1 for one cycle exactly 16 STB cycles in. bus CYC=0 thereafter. The DMA is then grantable.

Source files
------------

// File: rtl/wb_bus_arbiter_if.sv
// wb_bus_arbiter_if: Wishbone B4 signal bundle (32-bit address/data, 4 byte selects).
// The master modport drives the request side; the slave modport answers with data/ack/err.
interface wb_bus_arbiter_if;
   logic        cyc;
   logic        stb;
   logic        we;
   logic [3:0]  sel;
   logic [31:0] adr;
   logic [31:0] dat_o;
   logic [31:0] dat_i;
   logic        ack;
   logic        err;

   modport master (output cyc, stb, we, sel, adr, dat_o, input dat_i, ack, err);
   modport slave  (input cyc, stb, we, sel, adr, dat_o, output dat_i, ack, err);
endinterface

// File: rtl/wb_bus_arbiter.sv
// wb_bus_arbiter: two-master (CPU, DMA) Wishbone B4 arbiter granting whole CYC tenures.
// Define ARB_TIMEOUT_EN to add the watchdog that aborts a tenure stalled without ACK/ERR.
//
// state    | meaning
// IDLE     | no owner; bus outputs and both slave-port responses held at 0
// OWN_CPU  | CPU owns the tenure; bus muxed from cpu_wb, responses routed to CPU only
// OWN_DMA  | DMA owns the tenure; bus muxed from dma_wb, responses routed to DMA only
module wb_bus_arbiter #(
   parameter bit          FIXED_PRIORITY = 1'b0,
   parameter int unsigned TIMEOUT_CYCLES = 256,
   parameter int unsigned TO_WIDTH       = 9
) (
   input  logic             clk,
   input  logic             rst,
   wb_bus_arbiter_if.slave  cpu_wb,
   wb_bus_arbiter_if.slave  dma_wb,
   wb_bus_arbiter_if.master bus_wb,
   output logic [1:0]       grant,
   output logic             timeout_irq
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      OWN_CPU = 2'd1,
      OWN_DMA = 2'd2
   } state_e;

   state_e     state_q, state_d;
   logic       last_dma_q;
   logic [1:0] grant_q;
   logic       abort;
   logic       fire;

   if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > (32'd1 << TO_WIDTH)) begin : g_bad_timeout
      $error("TO_WIDTH too narrow for TIMEOUT_CYCLES");
   end

   // Ties go to the CPU under fixed priority, else to whoever did not own the bus last.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (cpu_wb.cyc && (!dma_wb.cyc || FIXED_PRIORITY || last_dma_q))
               state_d = OWN_CPU;
            else if (dma_wb.cyc)
               state_d = OWN_DMA;
         end
         OWN_CPU: if (!cpu_wb.cyc) state_d = dma_wb.cyc ? OWN_DMA : IDLE;
         OWN_DMA: if (!dma_wb.cyc) state_d = cpu_wb.cyc ? OWN_CPU : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= IDLE;
         last_dma_q <= 1'b1;
         grant_q    <= 2'b00;
      end else begin
         state_q <= state_d;
         grant_q <= {state_d == OWN_DMA, state_d == OWN_CPU};
         if (state_d == OWN_CPU)
            last_dma_q <= 1'b0;
         else if (state_d == OWN_DMA)
            last_dma_q <= 1'b1;
      end
   end

   assign grant = grant_q;

   always_comb begin
      bus_wb.cyc   = 1'b0;
      bus_wb.stb   = 1'b0;
      bus_wb.we    = 1'b0;
      bus_wb.sel   = 4'h0;
      bus_wb.adr   = 32'h0;
      bus_wb.dat_o = 32'h0;
      cpu_wb.ack   = 1'b0;
      cpu_wb.err   = 1'b0;
      cpu_wb.dat_i = 32'h0;
      dma_wb.ack   = 1'b0;
      dma_wb.err   = 1'b0;
      dma_wb.dat_i = 32'h0;
      case (state_q)
         OWN_CPU: begin
            bus_wb.cyc   = cpu_wb.cyc & ~abort;
            bus_wb.stb   = cpu_wb.stb & ~abort;
            bus_wb.we    = cpu_wb.we;
            bus_wb.sel   = cpu_wb.sel;
            bus_wb.adr   = cpu_wb.adr;
            bus_wb.dat_o = cpu_wb.dat_o;
            cpu_wb.ack   = bus_wb.ack;
            cpu_wb.err   = bus_wb.err | fire;
            cpu_wb.dat_i = bus_wb.dat_i;
         end
         OWN_DMA: begin
            bus_wb.cyc   = dma_wb.cyc & ~abort;
            bus_wb.stb   = dma_wb.stb & ~abort;
            bus_wb.we    = dma_wb.we;
            bus_wb.sel   = dma_wb.sel;
            bus_wb.adr   = dma_wb.adr;
            bus_wb.dat_o = dma_wb.dat_o;
            dma_wb.ack   = bus_wb.ack;
            dma_wb.err   = bus_wb.err | fire;
            dma_wb.dat_i = bus_wb.dat_i;
         end
         default: ;
      endcase
   end

`ifdef ARB_TIMEOUT_EN
   logic [TO_WIDTH-1:0] wd_cnt_q;
   logic                abort_q;
   logic                own_req;

   assign own_req = (state_q == OWN_CPU) ? (cpu_wb.cyc & cpu_wb.stb) :
                    (state_q == OWN_DMA) ? (dma_wb.cyc & dma_wb.stb) : 1'b0;

   // Fires from registered state only, so ERR and the irq are glitch-free single-cycle pulses.
   assign fire  = (state_q != IDLE) && !abort_q && (wd_cnt_q == TO_WIDTH'(TIMEOUT_CYCLES - 1));
   assign abort = abort_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         wd_cnt_q <= '0;
         abort_q  <= 1'b0;
      end else begin
         if (state_d != state_q || bus_wb.ack || bus_wb.err || fire)
            wd_cnt_q <= '0;
         else if (own_req && !abort_q)
            wd_cnt_q <= wd_cnt_q + 1'b1;

         if (state_d != state_q)
            abort_q <= 1'b0;
         else if (fire)
            abort_q <= 1'b1;
      end
   end

   assign timeout_irq = fire;
`else
   assign fire        = 1'b0;
   assign abort       = 1'b0;
   assign timeout_irq = 1'b0;
`endif

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// tb_wb_bus_arbiter: directed bench driving a round-robin and a fixed-priority arbiter
// with identical stimulus and comparing both against hand-computed expectations.
module tb_wb_bus_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic        c_cyc = 0, c_stb = 0, c_we = 0;
   logic [3:0]  c_sel = 0;
   logic [31:0] c_adr = 0, c_dat = 0;
   logic        d_cyc = 0, d_stb = 0, d_we = 0;
   logic [3:0]  d_sel = 0;
   logic [31:0] d_adr = 0, d_dat = 0;
   logic        s_ack = 0, s_err = 0;
   logic [31:0] s_dat = 0;

   int checks = 0;
   int failures = 0;

   wb_bus_arbiter_if cpu0 ();
   wb_bus_arbiter_if dma0 ();
   wb_bus_arbiter_if bus0 ();
   wb_bus_arbiter_if cpu1 ();
   wb_bus_arbiter_if dma1 ();
   wb_bus_arbiter_if bus1 ();

   assign cpu0.cyc = c_cyc;  assign cpu0.stb = c_stb;  assign cpu0.we = c_we;
   assign cpu0.sel = c_sel;  assign cpu0.adr = c_adr;  assign cpu0.dat_o = c_dat;
   assign dma0.cyc = d_cyc;  assign dma0.stb = d_stb;  assign dma0.we = d_we;
   assign dma0.sel = d_sel;  assign dma0.adr = d_adr;  assign dma0.dat_o = d_dat;
   assign bus0.ack = s_ack;  assign bus0.err = s_err;  assign bus0.dat_i = s_dat;
   assign cpu1.cyc = c_cyc;  assign cpu1.stb = c_stb;  assign cpu1.we = c_we;
   assign cpu1.sel = c_sel;  assign cpu1.adr = c_adr;  assign cpu1.dat_o = c_dat;
   assign dma1.cyc = d_cyc;  assign dma1.stb = d_stb;  assign dma1.we = d_we;
   assign dma1.sel = d_sel;  assign dma1.adr = d_adr;  assign dma1.dat_o = d_dat;
   assign bus1.ack = s_ack;  assign bus1.err = s_err;  assign bus1.dat_i = s_dat;

   logic [1:0] grant0, grant1;
   logic       irq0, irq1;

   wb_bus_arbiter #(.FIXED_PRIORITY(1'b0), .TIMEOUT_CYCLES(16), .TO_WIDTH(9)) u_rr (
      .clk(clk), .rst(rst), .cpu_wb(cpu0), .dma_wb(dma0), .bus_wb(bus0),
      .grant(grant0), .timeout_irq(irq0)
   );

   wb_bus_arbiter #(.FIXED_PRIORITY(1'b1), .TIMEOUT_CYCLES(16), .TO_WIDTH(9)) u_fp (
      .clk(clk), .rst(rst), .cpu_wb(cpu1), .dma_wb(dma1), .bus_wb(bus1),
      .grant(grant1), .timeout_irq(irq1)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      // reset state, with a stray slave ACK on the bus
      s_ack = 1'b1; s_dat = 32'h5555_5555;
      tick(); tick();
      settle();
      chk("rst_grant0", grant0, 2'b00);
      chk("rst_grant1", grant1, 2'b00);
      chk("rst_bus_cyc", bus0.cyc, 1'b0);
      chk("rst_bus_adr", bus0.adr, 32'h0);
      chk("rst_cpu_ack", cpu0.ack, 1'b0);
      chk("rst_cpu_dati", cpu0.dat_i, 32'h0);
      chk("rst_irq", irq0, 1'b0);
      rst = 1'b1;
      tick();
      settle();
      chk("idle_ack_drop", cpu0.ack, 1'b0);
      chk("idle_dma_ack_drop", dma0.ack, 1'b0);
      s_ack = 1'b0; s_dat = 32'h0;

      // 1: single CPU read
      c_cyc = 1; c_stb = 1; c_adr = 32'h1000; c_we = 0; c_sel = 4'hF;
      settle();
      chk("t1_grant_latency", grant0, 2'b00);
      chk("t1_bus_cyc_pre", bus0.cyc, 1'b0);
      tick();
      chk("t1_grant", grant0, 2'b01);
      chk("t1_bus_cyc", bus0.cyc, 1'b1);
      chk("t1_bus_adr", bus0.adr, 32'h1000);
      chk("t1_bus_we", bus0.we, 1'b0);
      s_ack = 1; s_dat = 32'hDEAD_BEEF;
      settle();
      chk("t1_cpu_ack", cpu0.ack, 1'b1);
      chk("t1_cpu_dati", cpu0.dat_i, 32'hDEAD_BEEF);
      chk("t1_dma_ack", dma0.ack, 1'b0);
      chk("t1_dma_dati", dma0.dat_i, 32'h0);
      tick();
      c_cyc = 0; c_stb = 0; s_ack = 0; s_dat = 0;
      settle();
      chk("t1_bus_cyc_drop", bus0.cyc, 1'b0);
      chk("t1_grant_hold", grant0, 2'b01);
      tick();
      chk("t1_idle", grant0, 2'b00);

      // 2/3: simultaneous requests from reset
      rst = 0; tick(); rst = 1;
      c_cyc = 1; c_stb = 1; c_adr = 32'h1000;
      d_cyc = 1; d_stb = 1; d_adr = 32'h2000; d_sel = 4'hF;
      tick();
      chk("t2_tie0_rr", grant0, 2'b01);
      chk("t2_tie0_fp", grant1, 2'b01);
      chk("t2_tie0_adr", bus0.adr, 32'h1000);
      c_cyc = 0; c_stb = 0;
      settle();
      chk("t2_handover_gap", bus0.cyc, 1'b0);
      tick();
      chk("t2_handover_rr", grant0, 2'b10);
      chk("t2_handover_fp", grant1, 2'b10);
      chk("t2_handover_cyc", bus0.cyc, 1'b1);
      chk("t2_handover_adr", bus0.adr, 32'h2000);
      d_cyc = 0; d_stb = 0;
      tick();
      chk("t2_idle", grant0, 2'b00);
      c_cyc = 1; c_stb = 1; d_cyc = 1; d_stb = 1;
      tick();
      chk("t2_tie1_rr", grant0, 2'b01);
      chk("t3_tie1_fp", grant1, 2'b01);
      c_cyc = 0; c_stb = 0; d_cyc = 0; d_stb = 0;
      tick();
      c_cyc = 1; c_stb = 1; d_cyc = 1; d_stb = 1;
      tick();
      chk("t2_tie2_rr", grant0, 2'b10);
      chk("t3_tie2_fp", grant1, 2'b01);
      c_cyc = 0; c_stb = 0; d_cyc = 0; d_stb = 0;
      tick();
      chk("t3_idle_fp", grant1, 2'b00);

      // 4: 8-word DMA burst, CPU waiting from the second beat
      d_cyc = 1; d_stb = 1; d_adr = 32'h2000; d_we = 1;
      tick();
      chk("t4_grant", grant0, 2'b10);
      for (int i = 0; i < 8; i++) begin
         d_adr = 32'h2000 + 32'(4 * i);
         s_ack = 1; s_dat = 32'(i);
         if (i >= 1) begin c_cyc = 1; c_stb = 1; c_adr = 32'h1004; end
         settle();
         chk("t4_adr", bus0.adr, 32'h2000 + 32'(4 * i));
         chk("t4_dma_ack", dma0.ack, 1'b1);
         chk("t4_cpu_ack", cpu0.ack, 1'b0);
         chk("t4_grant_hold", grant0, 2'b10);
         tick();
      end
      d_cyc = 0; d_stb = 0; d_we = 0; s_ack = 0; s_dat = 0;
      settle();
      chk("t4_end_grant", grant0, 2'b10);
      chk("t4_end_cyc", bus0.cyc, 1'b0);
      tick();
      chk("t4_cpu_grant", grant0, 2'b01);
      chk("t4_cpu_adr", bus0.adr, 32'h1004);

      // 5: reset in the middle of a DMA tenure with the CPU pending
      c_cyc = 0; c_stb = 0; d_cyc = 1; d_stb = 1;
      tick();
      chk("t5_dma_grant", grant0, 2'b10);
      c_cyc = 1; c_stb = 1; rst = 0; s_ack = 1;
      tick();
      chk("t5_rst_grant", grant0, 2'b00);
      chk("t5_rst_cyc", bus0.cyc, 1'b0);
      chk("t5_rst_ack", dma0.ack, 1'b0);
      rst = 1; s_ack = 0;
      tick();
      chk("t5_post_rr", grant0, 2'b01);
      chk("t5_post_fp", grant1, 2'b01);
      chk("t5_post_adr", bus0.adr, 32'h1004);
      c_cyc = 0; c_stb = 0; d_cyc = 0; d_stb = 0;
      tick();
      chk("t5_idle", grant0, 2'b00);

      // 6: CPU stalls on a slave that never answers
      c_cyc = 1; c_stb = 1; c_adr = 32'h3000;
      tick();
      chk("t6_grant", grant0, 2'b01);
`ifdef ARB_TIMEOUT_EN
      for (int k = 1; k <= 16; k++) begin
         chk("t6_stall_cyc", bus0.cyc, 1'b1);
         chk("t6_err", cpu0.err, (k == 16) ? 1'b1 : 1'b0);
         chk("t6_irq", irq0, (k == 16) ? 1'b1 : 1'b0);
         tick();
      end
      d_cyc = 1; d_stb = 1;
      for (int k = 0; k < 3; k++) begin
         chk("t6_abort_cyc", bus0.cyc, 1'b0);
         chk("t6_abort_err", cpu0.err, 1'b0);
         chk("t6_abort_irq", irq0, 1'b0);
         chk("t6_abort_grant", grant0, 2'b01);
         tick();
      end
      c_cyc = 0; c_stb = 0;
      tick();
      chk("t6_dma_grant", grant0, 2'b10);
      chk("t6_dma_cyc", bus0.cyc, 1'b1);
`else
      for (int k = 1; k <= 20; k++) begin
         chk("t6_hung_cyc", bus0.cyc, 1'b1);
         chk("t6_hung_err", cpu0.err, 1'b0);
         chk("t6_hung_irq", irq0, 1'b0);
         tick();
      end
      chk("t6_hung_grant", grant0, 2'b01);
      c_cyc = 0; c_stb = 0;
      tick();
      chk("t6_release", grant0, 2'b00);
`endif
      c_cyc = 0; c_stb = 0; d_cyc = 0; d_stb = 0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
